// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: alternates dark gaps and lit shows, picks the lit
// hole from a free-running LFSR and tallies rounds and hits for the score logic.
module mole_scheduler #(
    parameter logic [27:0] SHOW_BASE  = 28'd50_000_000,
    parameter logic [27:0] GAP_CYCLES = 28'd25_000_000,
    parameter logic [4:0]  ROUNDS     = 5'd30,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  level,
    input  logic        hit,
    output logic        mole_on,
    output logic [2:0]  mole_sel,
    output logic [4:0]  round,
    output logic [4:0]  score,
    output logic        busy,
    output logic        done,
    output logic [27:0] period
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GAP    = 2'd1,
        ST_SHOW   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [27:0] counter_r, counter_s;
    logic [1:0]  level_q_r, level_q_s;
    logic [7:0]  lfsr_r;
    logic        mole_on_r, mole_on_s;
    logic [2:0]  mole_sel_r, mole_sel_s;
    logic [4:0]  round_r, round_s;
    logic [4:0]  score_r, score_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [27:0] period_r, period_s;
    logic        round_end_s;
    logic        last_round_s;

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign round_end_s  = hit || (counter_r == 28'd0);
    assign last_round_s = ((round_r + 5'd1) == ROUNDS);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_GAP;
                else       state_s = ST_IDLE;
            end
            ST_GAP: begin
                if (counter_r == 28'd0) state_s = ST_SHOW;
                else                    state_s = ST_GAP;
            end
            ST_SHOW: begin
                if (round_end_s) begin
                    if (last_round_s) state_s = ST_FINISH;
                    else              state_s = ST_GAP;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Datapath and output next values; a hit on the last show cycle still scores
    always_comb begin
        counter_s  = counter_r;
        level_q_s  = level_q_r;
        mole_on_s  = mole_on_r;
        mole_sel_s = mole_sel_r;
        round_s    = round_r;
        score_s    = score_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        period_s   = period_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    level_q_s = level;
                    period_s  = SHOW_BASE >> level;
                    round_s   = 5'd0;
                    score_s   = 5'd0;
                    counter_s = GAP_CYCLES - 28'd1;
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_GAP: begin
                if (counter_r == 28'd0) begin
                    counter_s  = (SHOW_BASE >> level_q_r) - 28'd1;
                    mole_on_s  = 1'b1;
                    mole_sel_s = lfsr_r[2:0];
                end else begin
                    counter_s  = counter_r - 28'd1;
                end
            end
            ST_SHOW: begin
                if (round_end_s) begin
                    mole_on_s = 1'b0;
                    round_s   = round_r + 5'd1;
                    if (hit) score_s = score_r + 5'd1;
                    else     score_s = score_r;
                    if (last_round_s) begin
                        done_s    = 1'b1;
                        counter_s = 28'd0;
                    end else begin
                        counter_s = GAP_CYCLES - 28'd1;
                    end
                end else begin
                    counter_s = counter_r - 28'd1;
                end
            end
            ST_FINISH: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s    = 1'b0;
                mole_on_s = 1'b0;
                counter_s = 28'd0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_r  <= 28'd0;
            level_q_r  <= 2'd0;
            mole_on_r  <= 1'b0;
            mole_sel_r <= 3'd0;
            round_r    <= 5'd0;
            score_r    <= 5'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            period_r   <= 28'd0;
        end else begin
            counter_r  <= counter_s;
            level_q_r  <= level_q_s;
            mole_on_r  <= mole_on_s;
            mole_sel_r <= mole_sel_s;
            round_r    <= round_s;
            score_r    <= score_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            period_r   <= period_s;
        end
    end

    // Free-running hole picker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign mole_on  = mole_on_r;
    assign mole_sel = mole_sel_r;
    assign round    = round_r;
    assign score    = score_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign period   = period_r;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: a cycle-level behavioural model of the game rules is
// compared against every output each cycle, plus directed game-level expectations.
module tb_mole_scheduler;

    localparam logic [27:0] SB = 28'd16;
    localparam logic [27:0] GC = 28'd4;
    localparam logic [4:0]  RN = 5'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  level = 2'd0;
    logic        hit = 1'b0;
    logic        mole_on;
    logic [2:0]  mole_sel;
    logic [4:0]  round;
    logic [4:0]  score;
    logic        busy;
    logic        done;
    logic [27:0] period;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: interval-remaining view of the game
    bit         m_busy, m_show, m_done;
    int         m_left, m_round, m_score, m_period;
    logic [7:0] m_lfsr;
    logic [2:0] m_sel;

    mole_scheduler #(
        .SHOW_BASE(SB), .GAP_CYCLES(GC), .ROUNDS(RN), .LFSR_SEED(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .level(level), .hit(hit),
        .mole_on(mole_on), .mole_sel(mole_sel), .round(round), .score(score),
        .busy(busy), .done(done), .period(period)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_show = 1'b0; m_done = 1'b0;
        m_left = 0; m_round = 0; m_score = 0; m_period = 0;
        m_lfsr = 8'hA5; m_sel = 3'd0;
    endtask

    task automatic model_edge();
        if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_period = int'(SB) >> level;
                m_round = 0; m_score = 0; m_left = int'(GC);
            end
        end else if (!m_show) begin
            m_left--;
            if (m_left == 0) begin
                m_show = 1'b1; m_sel = m_lfsr[2:0]; m_left = m_period;
            end
        end else begin
            if (!hit) m_left--;
            if (hit || m_left == 0) begin
                m_show = 1'b0; m_round++;
                if (hit) m_score++;
                if (m_round == int'(RN)) m_done = 1'b1;
                else m_left = int'(GC);
            end
        end
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic compare_all();
        check("mole_on",  {31'd0, mole_on}, {31'd0, m_show});
        check("mole_sel", {29'd0, mole_sel}, {29'd0, m_sel});
        check("round",    {27'd0, round}, m_round);
        check("score",    {27'd0, score}, m_score);
        check("busy",     {31'd0, busy}, {31'd0, m_busy});
        check("done",     {31'd0, done}, {31'd0, m_done});
        check("period",   {4'd0, period}, m_period);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic cyc(input bit s, input logic [1:0] lv, input bit h);
        start = s; level = lv; hit = h;
        tick();
        start = 1'b0; hit = 1'b0;
    endtask

    // Reset lands mid-cycle so the asynchronous clear is visible before any edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic play(input logic [1:0] lv, input int hit_round, input int hit_at,
                        input bit gap_hits, input bit mid_start, input int abort_round,
                        input int hit_pct, output int len, output int dones);
        bit         h, s;
        logic [1:0] l;
        len = -1;
        dones = 0;
        cyc(1'b1, lv, 1'b0);
        for (int i = 1; i <= 400 && len < 0; i++) begin
            if (abort_round >= 0 && m_show && m_round == abort_round) begin
                do_reset();
                break;
            end
            h = 1'b0;
            s = 1'b0;
            l = 2'($urandom_range(0, 3));
            if (m_busy && m_show && !m_done && m_round == hit_round)
                h = (hit_at == 0) ? (m_left == 1) : ((m_period - m_left + 1) == hit_at);
            if (gap_hits && m_busy && !m_show) h = 1'b1;
            if (hit_pct > 0 && $urandom_range(0, 99) < hit_pct) h = 1'b1;
            if (hit_pct > 0 && $urandom_range(0, 15) == 0) s = 1'b1;
            if (mid_start && m_busy && !m_show && m_round == 1) s = 1'b1;
            cyc(s, l, h);
            if (done === 1'b1) begin
                dones++;
                len = i;
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'd0, 1'b0);
            if (done === 1'b1) dones++;
        end
    endtask

    int len, dones;

    initial begin
        model_reset();
        tick();
        tick();
        reset = 1'b0;

        // Idle: random level and stray hits must never start a game
        for (int i = 0; i < 100; i++) cyc(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 1'b1);

        // Level 0, no hits
        play(2'd0, -1, 0, 1'b0, 1'b0, -1, 0, len, dones);
        check("t2_len", len, 60);
        check("t2_dones", dones, 1);
        check("t2_round", {27'd0, round}, 3);
        check("t2_score", {27'd0, score}, 0);
        check("t2_period", {4'd0, period}, 16);
        check("t2_busy", {31'd0, busy}, 0);

        // Level 3: two-cycle shows
        play(2'd3, -1, 0, 1'b0, 1'b0, -1, 0, len, dones);
        check("t3_len", len, 18);
        check("t3_period", {4'd0, period}, 2);

        // Hit on 5th show cycle of the first round shortens it by 11 cycles
        play(2'd0, 0, 5, 1'b0, 1'b0, -1, 0, len, dones);
        check("t4_len", len, 49);
        check("t4_score", {27'd0, score}, 1);
        check("t4_round", {27'd0, round}, 3);

        // Hit on final show cycle, hits in gaps/finish, start mid-game
        play(2'd0, 2, 0, 1'b1, 1'b1, -1, 0, len, dones);
        check("t5_len", len, 60);
        check("t5_dones", dones, 1);
        check("t5_score", {27'd0, score}, 1);

        // Reset during the second show, then a full level-1 game
        play(2'd0, -1, 0, 1'b0, 1'b0, 1, 0, len, dones);
        check("t6_dones", dones, 0);
        check("t6_round", {27'd0, round}, 0);
        play(2'd1, -1, 0, 1'b0, 1'b0, -1, 0, len, dones);
        check("t6_len", len, 36);
        check("t6_round_full", {27'd0, round}, 3);

        // Randomized games against the model
        for (int g = 0; g < 8; g++) begin
            play(2'($urandom_range(0, 3)), -1, 0, 1'b0, 1'b0, -1, 12, len, dones);
            check("rnd_dones", dones, 1);
            for (int i = 0; i < int'($urandom_range(0, 5)); i++) cyc(1'b0, 2'd0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
